// File: rtl/line_window_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : line_window_gen                                            |
// | Purpose  : sliding KxK window over a column stream, stride/row-wrap   |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module line_window_gen #(
  parameter int KER_SIZE = 3,
  parameter int BITWIDTH = 8,
  parameter int STRIDE   = 1,
  parameter int IMG_W    = 28,
  parameter int AW       = 8
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  flush,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [BITWIDTH*KER_SIZE-1:0]          in_col,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [BITWIDTH*KER_SIZE*KER_SIZE-1:0] out_window,
  output logic [AW-1:0]                         out_x,
  output logic                                  out_last
);

  localparam int c_COL_W = BITWIDTH * KER_SIZE;
  localparam int c_PTR_W = $clog2(KER_SIZE);

  logic [c_COL_W-1:0]          r_col [KER_SIZE];
  logic [c_PTR_W-1:0]          r_wr_ptr;
  logic [AW-1:0]               r_col_cnt;
  logic [AW-1:0]               r_stride_cnt;
  logic [AW-1:0]               r_x_cnt;
  logic                        r_out_valid;
  logic [c_COL_W*KER_SIZE-1:0] r_out_window;
  logic [AW-1:0]               r_out_x;
  logic                        r_out_last;

  logic                        w_accept;
  logic                        w_filled;
  logic                        w_emit;
  logic                        w_wrap;
  logic                        w_last;
  logic [c_COL_W*KER_SIZE-1:0] w_window;

  assign in_ready = (!r_out_valid || out_ready) && !flush;
  assign w_accept = in_valid && in_ready;
  assign w_filled = r_col_cnt >= AW'(KER_SIZE - 1);
  assign w_emit   = w_accept && w_filled && (r_stride_cnt == '0);
  assign w_wrap   = r_col_cnt == AW'(IMG_W - 1);
  assign w_last   = ({1'b0, r_col_cnt} + (AW+1)'(STRIDE)) > (AW+1)'(IMG_W - 1);

  // Slot j (0 = oldest) reads column[wr_ptr+1+j mod K]; the newest slot is the live input.
  for (genvar j = 0; j < KER_SIZE - 1; j++) begin : g_win
    logic [c_PTR_W:0] w_idx_sum;
    logic [c_PTR_W:0] w_idx;
    assign w_idx_sum = {1'b0, r_wr_ptr} + (c_PTR_W+1)'(j + 1);
    assign w_idx     = (w_idx_sum >= (c_PTR_W+1)'(KER_SIZE)) ?
                       w_idx_sum - (c_PTR_W+1)'(KER_SIZE) : w_idx_sum;
    assign w_window[j*c_COL_W +: c_COL_W] = r_col[w_idx[c_PTR_W-1:0]];
  end
  assign w_window[(KER_SIZE-1)*c_COL_W +: c_COL_W] = in_col;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < KER_SIZE; i++) r_col[i] <= '0;
      r_wr_ptr     <= '0;
      r_col_cnt    <= '0;
      r_stride_cnt <= '0;
      r_x_cnt      <= '0;
      r_out_valid  <= 1'b0;
      r_out_window <= '0;
      r_out_x      <= '0;
      r_out_last   <= 1'b0;
    end else if (flush) begin
      r_wr_ptr     <= '0;
      r_col_cnt    <= '0;
      r_stride_cnt <= '0;
      r_x_cnt      <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_col[r_wr_ptr] <= in_col;
        r_wr_ptr <= (r_wr_ptr == c_PTR_W'(KER_SIZE - 1)) ? '0 : r_wr_ptr + 1'b1;
        if (w_wrap) begin
          r_col_cnt    <= '0;
          r_stride_cnt <= '0;
          r_x_cnt      <= '0;
        end else begin
          r_col_cnt <= r_col_cnt + 1'b1;
          if (w_filled)
            r_stride_cnt <= (r_stride_cnt == AW'(STRIDE - 1)) ? '0 : r_stride_cnt + 1'b1;
          if (w_emit)
            r_x_cnt <= r_x_cnt + 1'b1;
        end
      end
      if (w_emit) begin
        r_out_valid  <= 1'b1;
        r_out_window <= w_window;
        r_out_x      <= r_x_cnt;
        r_out_last   <= w_last;
      end else if (out_ready) begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_window = r_out_window;
  assign out_x      = r_out_x;
  assign out_last   = r_out_last;

endmodule
`default_nettype wire

// File: tb/tb_line_window_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_line_window_gen                                         |
// | Purpose  : scoreboard bench over five kernel/stride/width variants    |
// | Revision : 1.0  initial release                                       |
// +-----------------------------------------------------------------------+
module tb_line_window_gen;

  localparam int NI = 5;
  localparam int KP[NI] = '{3, 3, 3, 5, 2};
  localparam int SP[NI] = '{1, 2, 2, 1, 1};
  localparam int WP[NI] = '{6, 7, 8, 8, 4};

  typedef struct {
    logic [511:0] w;
    int           x;
    bit           last;
  } exp_t;

  typedef struct {
    int inst;
    int ncols;
    int hold;
    int wins;
    int lasts;
    int last_x;
  } scn_t;

  logic        clk;
  logic        rstn;
  logic [NI-1:0] fl, iv, irdy, ov, ordy, olast;
  logic [63:0]  ic [NI];
  logic [511:0] ow [NI];
  logic [7:0]   ox [NI];

  int checks = 0;
  int errors = 0;

  // reference model state
  bit           eov [NI];
  bit           acc [NI];
  int           cnt [NI];
  logic [63:0]  row [NI][16];
  exp_t         q   [NI][$];
  int           seen [NI];
  int           nlast [NI];
  int           last_x [NI];
  int           first_x [NI];
  logic [63:0]  colv [16];
  scn_t         tbl [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int K = KP[g];
    logic [8*K*K-1:0] w_win;
    logic [7:0]       w_x;
    line_window_gen #(
      .KER_SIZE(K), .BITWIDTH(8), .STRIDE(SP[g]), .IMG_W(WP[g]), .AW(8)
    ) u_dut (
      .clk(clk), .rstn(rstn), .flush(fl[g]),
      .in_valid(iv[g]), .in_ready(irdy[g]), .in_col(ic[g][8*K-1:0]),
      .out_valid(ov[g]), .out_ready(ordy[g]),
      .out_window(w_win), .out_x(w_x), .out_last(olast[g])
    );
    assign ow[g] = 512'(w_win);
    assign ox[g] = w_x;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int i, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0h expected %0h", name, i, act, exp);
    end
  endtask

  // Monitor and model: compare current outputs, then advance the model by one cycle.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      bit eready;
      bit emit;
      exp_t e;
      if (!rstn) begin
        eov[i] = 0; acc[i] = 0; cnt[i] = 0; q[i].delete();
        continue;
      end
      eready = (!eov[i] || ordy[i]) && !fl[i];
      chk("in_ready", i, 512'(irdy[i]), 512'(eready));
      chk("out_valid", i, 512'(ov[i]), 512'(eov[i]));
      if (eov[i]) begin
        if (q[i].size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard_empty inst%0d: got empty queue required one entry", i);
        end else begin
          e = q[i][0];
          chk("out_window", i, ow[i], e.w);
          chk("out_x", i, 512'(ox[i]), 512'(e.x));
          chk("out_last", i, 512'(olast[i]), 512'(e.last));
          if (ordy[i]) void'(q[i].pop_front());
        end
      end
      if (ov[i] && ordy[i]) begin
        if (seen[i] == 0) first_x[i] = int'(ox[i]);
        seen[i]++;
        if (olast[i]) begin nlast[i]++; last_x[i] = int'(ox[i]); end
      end
      acc[i] = iv[i] && eready;
      if (fl[i]) begin
        eov[i] = 0; cnt[i] = 0; q[i].delete();
      end else begin
        emit = 0;
        if (acc[i]) begin
          logic [63:0] mask;
          mask = (64'd1 << (KP[i]*8)) - 64'd1;
          row[i][cnt[i]] = ic[i] & mask;
          if (cnt[i] >= KP[i]-1 && ((cnt[i]-(KP[i]-1)) % SP[i]) == 0) begin
            emit = 1;
            e.w = '0;
            for (int j = 0; j < KP[i]; j++)
              e.w = e.w | (512'(row[i][cnt[i]-(KP[i]-1)+j]) << (j*KP[i]*8));
            e.x = (cnt[i]-(KP[i]-1)) / SP[i];
            e.last = (cnt[i] + SP[i]) > (WP[i] - 1);
            q[i].push_back(e);
          end
          cnt[i] = (cnt[i] == WP[i]-1) ? 0 : cnt[i] + 1;
        end
        if (emit) eov[i] = 1;
        else if (ordy[i]) eov[i] = 0;
      end
    end
  end

  task automatic clr_stats(input int i);
    seen[i] = 0; nlast[i] = 0; last_x[i] = -1; first_x[i] = -1;
  endtask

  task automatic drive(input int i, input int n, input int hold);
    int k = 0;
    int held = 0;
    int cyc = 0;
    while (k < n && cyc < 300) begin
      iv[i] = 1'b1;
      ic[i] = colv[k];
      ordy[i] = !(hold > 0 && eov[i] && held < hold);
      if (!ordy[i]) held++;
      @(posedge clk); #1;
      cyc++;
      if (acc[i]) k++;
    end
    iv[i] = 1'b0;
    ordy[i] = 1'b1;
    if (cyc >= 300) begin
      checks++; errors++;
      $display("FAIL drive_timeout inst%0d: got %0d columns accepted required %0d", i, k, n);
    end
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic run_scn(input int s);
    int i;
    i = tbl[s].inst;
    clr_stats(i);
    for (int k = 0; k < 16; k++) colv[k] = {$urandom, $urandom};
    drive(i, tbl[s].ncols, tbl[s].hold);
    drain();
    chk("win_count", i, 512'(seen[i]), 512'(tbl[s].wins));
    chk("last_count", i, 512'(nlast[i]), 512'(tbl[s].lasts));
    chk("last_x", i, 512'(last_x[i]), 512'(tbl[s].last_x));
    chk("first_x", i, 512'(first_x[i]), 512'(0));
  endtask

  initial begin
    tbl[0] = '{inst: 0, ncols: 6, hold: 0, wins: 4, lasts: 1, last_x: 3};
    tbl[1] = '{inst: 1, ncols: 7, hold: 0, wins: 3, lasts: 1, last_x: 2};
    tbl[2] = '{inst: 2, ncols: 8, hold: 0, wins: 3, lasts: 1, last_x: 2};
    tbl[3] = '{inst: 3, ncols: 8, hold: 3, wins: 4, lasts: 1, last_x: 3};
    tbl[4] = '{inst: 4, ncols: 8, hold: 0, wins: 6, lasts: 2, last_x: 2};

    fl = '0; iv = '0; ordy = '1;
    for (int i = 0; i < NI; i++) begin ic[i] = '0; clr_stats(i); end
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #2;
    for (int i = 0; i < NI; i++) begin
      chk("rst_out_valid", i, 512'(ov[i]), '0);
      chk("rst_out_window", i, ow[i], '0);
      chk("rst_out_x", i, 512'(ox[i]), '0);
      chk("rst_out_last", i, 512'(olast[i]), '0);
      chk("rst_in_ready", i, 512'(irdy[i]), 512'(1));
    end
    @(negedge clk); #2 rstn = 1'b1;
    @(posedge clk); #1;

    for (int s = 0; s < NI; s++) run_scn(s);

    // flush after four columns of a row; the flush-cycle column must be dropped
    clr_stats(0);
    for (int k = 0; k < 16; k++) colv[k] = {$urandom, $urandom};
    drive(0, 4, 0);
    chk("pre_flush_wins", 0, 512'(seen[0]), 512'(1));
    fl[0] = 1'b1; iv[0] = 1'b1; ic[0] = 64'hdead_beef_cafe_f00d;
    @(posedge clk); #1;
    fl[0] = 1'b0; iv[0] = 1'b0;
    chk("flush_out_valid", 0, 512'(ov[0]), '0);
    clr_stats(0);
    for (int k = 0; k < 16; k++) colv[k] = {$urandom, $urandom};
    drive(0, 3, 0);
    drain();
    chk("post_flush_wins", 0, 512'(seen[0]), 512'(1));
    chk("post_flush_x", 0, 512'(first_x[0]), '0);

    // asynchronous reset while a window is held under backpressure
    for (int k = 0; k < 16; k++) colv[k] = {$urandom, $urandom};
    drive(0, 3, 0);
    ordy[0] = 1'b0;
    chk("pre_rst_valid", 0, 512'(ov[0]), 512'(1));
    #2 rstn = 1'b0;
    #1;
    chk("arst_out_valid", 0, 512'(ov[0]), '0);
    chk("arst_out_window", 0, ow[0], '0);
    chk("arst_out_x", 0, 512'(ox[0]), '0);
    chk("arst_out_last", 0, 512'(olast[0]), '0);
    chk("arst_in_ready", 0, 512'(irdy[0]), 512'(1));
    @(negedge clk); #2 rstn = 1'b1;
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 0, 512'(irdy[0]), 512'(1));
    run_scn(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/line_window_gen.md
# line_window_gen

Parametrised sliding-window generator for the conv datapath. It accepts one kernel-height column of pixels per handshake and keeps the last KER_SIZE columns in circular registers. It emits a registered KER_SIZE×KER_SIZE window with stride, row-wrap and backpressure support. The column pointer, fill state and output gating are internal, so it drops in between the row-line SRAM readout and the MAC array for any kernel size from 2 to 8.

## Interface
- KER_SIZE, 3, kernel height/width; legal 2..8
- BITWIDTH, 8, bits per pixel
- STRIDE, 1, horizontal stride; legal 1..KER_SIZE
- IMG_W, 28, columns per row; legal KER_SIZE..2^AW-1
- AW, 8, width of column counters and out_x
- clk  in  1  single clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of row state and output register
- in_valid  in  1  in_col valid
- in_ready  out  1  block can accept in_col this cycle
- in_col  in  BITWIDTH*KER_SIZE  one column; row 0 in LSBs
- out_valid  out  1  out_window valid
- out_ready  in  1  consumer accepts out_window
- out_window  out  BITWIDTH*KER_SIZE*KER_SIZE  window; newest column in MSBs, oldest in LSBs
- out_x  out  AW  output-column index of the window within the row (0,1,2,…)
- out_last  out  1  final window of the current row

## Operation
- Storage: KER_SIZE column registers plus wr_ptr (mod KER_SIZE) and col_cnt (0..IMG_W-1).
- Accept = in_valid && in_ready.
- in_ready = (!out_valid || out_ready) && !flush.
- On accept:
  - write in_col to column[wr_ptr]; wr_ptr = wr_ptr+1 mod KER_SIZE.
  - col_cnt = col_cnt+1, wrapping to 0 after IMG_W-1.
  - On wrap, fill state resets, so the new row never mixes in previous-row columns.
- Emit condition on accept: col_cnt ≥ KER_SIZE-1 and (col_cnt-(KER_SIZE-1)) mod STRIDE == 0.
  - Use a stride counter; no divider.
- Window on emit: {in_col, column[wr_ptr-1], …, column[wr_ptr-(KER_SIZE-1)]}, with pointer arithmetic mod KER_SIZE.
- out_x = (col_cnt-(KER_SIZE-1))/STRIDE, maintained as an incrementing counter that clears at row wrap.
- out_last = 1 on the emitted window where col_cnt+STRIDE > IMG_W-1.
  - Trailing columns that cannot form a full stride step produce no window.
- Output register:
  - On an accept that emits: load out_window, out_x and out_last; set out_valid.
  - Else if out_ready: clear out_valid; data holds.
- Non-emitting accepts still need in_ready, because accepts are gated by output-register availability.
- flush (priority over everything):
  - out_valid=0; wr_ptr=0; col_cnt=0; stride and out_x counters = 0.
  - Column registers are not cleared.
  - in_col presented in the same cycle is not accepted.
- rstn low: all state and outputs cleared asynchronously.

## Timing
- Reset values: out_valid=0, out_window=0, out_x=0, out_last=0, in_ready=1. Internal counters are 0 and column registers are 0.
- Latency: a window appears on out_valid the cycle after the accept of its newest column.
- Throughput: 1 column/cycle when out_ready is held high. A full-rate stream with STRIDE=1 sustains 1 window/cycle after the KER_SIZE-1 fill columns.
- Backpressure: while out_valid && !out_ready, in_ready=0. out_window, out_x and out_last are stable until the handshake.
- Simultaneous output handshake and emitting accept: the new window replaces the old one with no bubble, and out_valid stays 1.
- Row wrap: the first window of the next row requires KER_SIZE fresh columns; no window spans rows.
- Reset or flush mid-row: the next accepted column is treated as column 0 of a new row.

## Test plan
- K=3, S=1, W=6, columns c0..c5 at full rate, out_ready=1:
  - 4 windows, out_x=0..3.
  - First window is {c2,c1,c0} on the cycle after c2 is accepted.
  - out_last only on out_x=3.
- K=3, S=2, W=7: windows only after c2, c4, c6; out_x=0,1,2; out_last on out_x=2. K=3, S=2, W=8: c7 produces nothing, and out_last is still on out_x=2.
- K=5, S=1, W=8 with out_ready low for 3 cycles after the first window:
  - in_ready=0 and out_window stable for those cycles.
  - No column lost; windows out_x=0..3 arrive in order with correct contents.
- Two rows back-to-back, K=2, W=4, row A=a0..a3, row B=b0..b3:
  - Windows {a1,a0},{a2,a1},{a3,a2},{b1,b0},…
  - No {b0,a3} window.
- flush asserted after c3 of a K=3, W=6 row with in_valid=1:
  - Column in the flush cycle is not accepted, and out_valid drops.
  - The next 3 columns produce a window with out_x=0.
- rstn pulsed low mid-row with out_valid=1:
  - All outputs go to 0 immediately, and in_ready=1 after release.
  - Behaviour matches the first scenario from scratch.
